// File: rtl/ethernet_smi_master.sv
// rtl/ethernet_smi_master.sv - clause-22 SMI/MDIO management master
// Purpose: serialises clause-22 MDIO read/write frames towards a PHY and
//          collects read data. MDIO is split into o/oe/i so a tri-state
//          buffer at the top level can drive the shared pin.
// Ports:
//   clk, reset              system clock, asynchronous active-low reset
//   start, write            request (taken while ready) and direction
//   phy_addr, register      PHY address and register address
//   content                 write data
//   ethernet_mdc            management clock to the PHY
//   ethernet_mdio_o/oe/i    split MDIO pin (oe=1 drives mdio_o)
//   ready                   idle, may accept start
//   read_data, read_valid   last read word and its one-cycle strobe
//   ack_error               PHY did not pull TA low on the last read
module ethernet_smi_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  register,
  input  logic [15:0] content,
  output logic        ethernet_mdc,
  output logic        ethernet_mdio_o,
  output logic        ethernet_mdio_oe,
  input  logic        ethernet_mdio_i,
  output logic        ready,
  output logic [15:0] read_data,
  output logic        read_valid,
  output logic        ack_error
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]      PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [31:0]      tx_shift;
  logic [15:0]      rx_shift;
  logic             is_write;
  logic             end_half;
  logic [31:0]      frame;

  // Frame from ST onwards. For reads the TA/DATA slots are placeholders:
  // the pin is released there, so their value never reaches the PHY.
  always_comb begin
    frame = {2'b01, (write ? 2'b01 : 2'b10), phy_addr, register,
             (write ? {2'b10, content} : 18'h3ffff)};
  end

  // tx_shift always holds the bits still to be sent after the one on the pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      tx_shift         <= '0;
      rx_shift         <= '0;
      is_write         <= 1'b0;
      end_half         <= 1'b0;
      ethernet_mdc     <= 1'b0;
      ethernet_mdio_o  <= 1'b1;
      ethernet_mdio_oe <= 1'b0;
      ready            <= 1'b1;
      read_data        <= '0;
      read_valid       <= 1'b0;
      ack_error        <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          is_write         <= write;
          ack_error        <= 1'b0;
          ready            <= 1'b0;
          div_cnt          <= '0;
          bit_cnt          <= '0;
          end_half         <= 1'b0;
          ethernet_mdio_oe <= 1'b1;
          if (PREAMBLE_LEN > 0) begin
            state           <= S_PRE;
            ethernet_mdio_o <= 1'b1;
            tx_shift        <= frame;
          end else begin
            state           <= S_HDR;
            ethernet_mdio_o <= frame[31];
            tx_shift        <= {frame[30:0], 1'b0};
          end
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
        if (state == S_END) begin
          // MDC stays low for two divider periods before going idle.
          end_half <= ~end_half;
          if (end_half) begin
            state <= S_IDLE;
            ready <= 1'b1;
            if (!is_write) begin
              read_data  <= rx_shift;
              read_valid <= 1'b1;
            end
          end
        end else if (!ethernet_mdc) begin
          // Rising MDC: the PHY's bit is sampled on this edge.
          ethernet_mdc <= 1'b1;
          if (!is_write && state == S_TA && bit_cnt == 6'd1)
            ack_error <= ethernet_mdio_i;
          if (!is_write && state == S_DATA)
            rx_shift <= {rx_shift[14:0], ethernet_mdio_i};
        end else begin
          // Falling MDC: present the next bit.
          ethernet_mdc <= 1'b0;
          bit_cnt      <= bit_cnt + 6'd1;
          case (state)
            S_PRE: begin
              if (bit_cnt == PRE_LAST) begin
                state           <= S_HDR;
                bit_cnt         <= '0;
                ethernet_mdio_o <= tx_shift[31];
                tx_shift        <= {tx_shift[30:0], 1'b0};
              end else begin
                ethernet_mdio_o <= 1'b1;
              end
            end
            S_HDR: begin
              if (bit_cnt == 6'd13) begin
                state   <= S_TA;
                bit_cnt <= '0;
                if (!is_write) ethernet_mdio_oe <= 1'b0;
              end
              ethernet_mdio_o <= tx_shift[31];
              tx_shift        <= {tx_shift[30:0], 1'b0};
            end
            S_TA: begin
              if (bit_cnt == 6'd1) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end
              ethernet_mdio_o <= tx_shift[31];
              tx_shift        <= {tx_shift[30:0], 1'b0};
            end
            S_DATA: begin
              if (bit_cnt == 6'd15) begin
                state            <= S_END;
                bit_cnt          <= '0;
                ethernet_mdio_oe <= 1'b0;
                ethernet_mdio_o  <= 1'b1;
              end else begin
                ethernet_mdio_o <= tx_shift[31];
                tx_shift        <= {tx_shift[30:0], 1'b0};
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ethernet_smi_master.sv
// tb/tb_ethernet_smi_master.sv - self-checking bench for ethernet_smi_master
module tb_ethernet_smi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b, write;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] content;
  logic        mdio_i_a, mdio_i_b;
  logic        mdc_a, o_a, oe_a, ready_a, rv_a, ack_a;
  logic        mdc_b, o_b, oe_b, ready_b, rv_b, ack_b;
  logic [15:0] rd_a, rd_b;

  int checks = 0;
  int errors = 0;

  ethernet_smi_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .write(write),
    .phy_addr(phy_addr), .register(reg_addr), .content(content),
    .ethernet_mdc(mdc_a), .ethernet_mdio_o(o_a), .ethernet_mdio_oe(oe_a),
    .ethernet_mdio_i(mdio_i_a), .ready(ready_a), .read_data(rd_a),
    .read_valid(rv_a), .ack_error(ack_a));

  ethernet_smi_master #(.CLK_DIV(3), .PREAMBLE_LEN(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .write(write),
    .phy_addr(phy_addr), .register(reg_addr), .content(content),
    .ethernet_mdc(mdc_b), .ethernet_mdio_o(o_b), .ethernet_mdio_oe(oe_b),
    .ethernet_mdio_i(mdio_i_b), .ready(ready_b), .read_data(rd_b),
    .read_valid(rv_b), .ack_error(ack_b));

  int sel = 0;
  logic        mdc_s, o_s, oe_s, ready_s, rv_s, ack_s;
  logic [15:0] rd_s;
  assign mdc_s   = (sel != 0) ? mdc_b   : mdc_a;
  assign o_s     = (sel != 0) ? o_b     : o_a;
  assign oe_s    = (sel != 0) ? oe_b    : oe_a;
  assign ready_s = (sel != 0) ? ready_b : ready_a;
  assign rv_s    = (sel != 0) ? rv_b    : rv_a;
  assign ack_s   = (sel != 0) ? ack_b   : ack_a;
  assign rd_s    = (sel != 0) ? rd_b    : rd_a;

  // Observations of the latest frame.
  logic        cap_bits[$];
  logic        cap_oe[$];
  int          tog_cyc[$];
  int          ready_at, rv_cnt;
  logic        ready_drop;
  logic [15:0] rd_at_ready;
  logic        ack_at_ready, rv_at_ready, o_at_ready, oe_at_ready;
  logic        ack_at_accept, ready_at_accept;
  logic [15:0] exp_rd[2];

  // Behavioural PHY: what it places on MDIO for frame bit k.
  function automatic logic phy_bit(input int k, input int pl, input logic ta, input logic [15:0] pd);
    if (k == pl + 15) return ta;
    if (k >= pl + 16 && k < pl + 32) return pd[15 - (k - pl - 16)];
    return 1'b1;
  endfunction

  task automatic drive_phy(input int s, input logic v);
    if (s != 0) mdio_i_b = v;
    else        mdio_i_a = v;
  endtask

  // Number of driven frame bits that differ from the clause-22 frame layout.
  function automatic int bit_diffs(input int pl, input logic wr, input logic [4:0] pa,
                                   input logic [4:0] ra, input logic [15:0] dat);
    logic exp[$];
    int   n = 0;
    for (int i = 0; i < pl; i++) exp.push_back(1'b1);
    exp.push_back(1'b0); exp.push_back(1'b1);
    exp.push_back(!wr);  exp.push_back(wr);
    for (int i = 4; i >= 0; i--) exp.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) exp.push_back(ra[i]);
    exp.push_back(1'b1); exp.push_back(1'b0);
    for (int i = 15; i >= 0; i--) exp.push_back(dat[i]);
    if (cap_bits.size() != exp.size()) return 999;
    for (int k = 0; k < exp.size(); k++)
      if ((wr || k < pl + 14) && cap_bits[k] !== exp[k]) n++;
    return n;
  endfunction

  // Cycles where oe differs from: driven whole frame (write) or up to TA (read).
  function automatic int oe_diffs(input int pl, input int cd, input logic wr);
    int n = 0;
    int fb = (pl + 32) * 2 * cd;
    for (int c = 0; c < cap_oe.size(); c++) begin
      logic e;
      if (c < fb) e = wr ? 1'b1 : logic'((c / (2 * cd)) < pl + 14);
      else        e = 1'b0;
      if (cap_oe[c] !== e) n++;
    end
    if (cap_oe.size() != (pl + 33) * 2 * cd) n++;
    return n;
  endfunction

  // MDC toggles must fall exactly every cd cycles from the accept edge.
  function automatic int phase_diffs(input int cd, input int nbits);
    int n = 0;
    if (tog_cyc.size() != 2 * nbits) return 999;
    for (int i = 0; i < tog_cyc.size(); i++)
      if (tog_cyc[i] != (i + 1) * cd) n++;
    return n;
  endfunction

  // Issues one request and records what the DUT does until shortly after ready.
  task automatic run_frame(input int s, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] dat, input logic ta, input logic [15:0] pd,
                           input logic disturb, input int rst_at);
    int   cd = (s != 0) ? 3 : 2;
    int   pl = (s != 0) ? 0 : 32;
    int   budget = (pl + 33) * 2 * cd + 40;
    logic prev;
    cap_bits.delete(); cap_oe.delete(); tog_cyc.delete();
    ready_at = -1; rv_cnt = 0; ready_drop = 1'b0;
    sel = s;
    @(negedge clk);
    write = wr; phy_addr = pa; reg_addr = ra; content = dat;
    drive_phy(s, phy_bit(0, pl, ta, pd));
    if (s != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    ready_at_accept = ready_s;
    ack_at_accept   = ack_s;
    write = 1'($urandom); phy_addr = 5'($urandom); reg_addr = 5'($urandom); content = 16'($urandom);
    cap_oe.push_back(oe_s);
    prev = mdc_s;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (disturb && cyc == 40) begin
        reg_addr = 5'($urandom); content = 16'($urandom);
        if (s != 0) start_b = 1'b1; else start_a = 1'b1;
      end
      if (cyc == 41) begin start_a = 1'b0; start_b = 1'b0; end
      @(posedge clk); #1;
      if (cyc == rst_at) begin
        reset = 1'b0;
        #1;
        return;
      end
      if (rv_s === 1'b1) rv_cnt++;
      if (mdc_s !== prev) begin
        tog_cyc.push_back(cyc);
        if (mdc_s === 1'b1) begin
          cap_bits.push_back(o_s);
          drive_phy(s, phy_bit(cap_bits.size(), pl, ta, pd));
        end
        prev = mdc_s;
      end
      if (ready_at < 0) begin
        if (ready_s === 1'b1) begin
          ready_at = cyc; rd_at_ready = rd_s; ack_at_ready = ack_s;
          rv_at_ready = rv_s; o_at_ready = o_s; oe_at_ready = oe_s;
        end else begin
          cap_oe.push_back(oe_s);
        end
      end else begin
        if (ready_s !== 1'b1) ready_drop = 1'b1;
        if (cyc >= ready_at + 8) break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (mdc_a !== 1'b0 || mdc_b !== 1'b0) begin errors++; $display("FAIL reset_mdc: got %b%b expected 00", mdc_a, mdc_b); end
    checks++; if (o_a !== 1'b1 || oe_a !== 1'b0 || o_b !== 1'b1 || oe_b !== 1'b0) begin errors++; $display("FAIL reset_mdio: got o=%b%b oe=%b%b expected o=11 oe=00", o_a, o_b, oe_a, oe_b); end
    checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b%b expected 11", ready_a, ready_b); end
    checks++; if (rd_a !== 16'h0 || rd_b !== 16'h0 || rv_a !== 1'b0 || rv_b !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin errors++; $display("FAIL reset_read: got rd=%h/%h rv=%b%b ack=%b%b expected zeros", rd_a, rd_b, rv_a, rv_b, ack_a, ack_b); end
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
  endtask

  task automatic test_write;
    run_frame(0, 1'b1, 5'd1, 5'd0, 16'h8000, 1'b0, 16'h0, 1'b0, -1);
    checks++; if (ready_at_accept !== 1'b0) begin errors++; $display("FAIL write_accept_ready: got %b expected 0", ready_at_accept); end
    checks++; if (bit_diffs(32, 1'b1, 5'd1, 5'd0, 16'h8000) != 0) begin errors++; $display("FAIL write_bits: got %0d bad bits expected 0", bit_diffs(32, 1'b1, 5'd1, 5'd0, 16'h8000)); end
    checks++; if (oe_diffs(32, 2, 1'b1) != 0) begin errors++; $display("FAIL write_oe: got %0d bad cycles expected 0", oe_diffs(32, 2, 1'b1)); end
    checks++; if (phase_diffs(2, 64) != 0) begin errors++; $display("FAIL write_mdc_phase: got %0d bad toggles expected 0", phase_diffs(2, 64)); end
    checks++; if (ready_at != 260) begin errors++; $display("FAIL write_ready_time: got %0d expected 260", ready_at); end
    checks++; if (rv_cnt != 0) begin errors++; $display("FAIL write_read_valid: got %0d pulses expected 0", rv_cnt); end
    checks++; if (o_at_ready !== 1'b1 || oe_at_ready !== 1'b0) begin errors++; $display("FAIL write_idle_pin: got o=%b oe=%b expected o=1 oe=0", o_at_ready, oe_at_ready); end
  endtask

  task automatic test_read;
    run_frame(0, 1'b0, 5'h11, 5'h02, 16'h0, 1'b0, 16'h1234, 1'b0, -1);
    checks++; if (bit_diffs(32, 1'b0, 5'h11, 5'h02, 16'h0) != 0) begin errors++; $display("FAIL read_hdr_bits: got %0d bad bits expected 0", bit_diffs(32, 1'b0, 5'h11, 5'h02, 16'h0)); end
    checks++; if (oe_diffs(32, 2, 1'b0) != 0) begin errors++; $display("FAIL read_oe: got %0d bad cycles expected 0", oe_diffs(32, 2, 1'b0)); end
    checks++; if (rd_at_ready !== 16'h1234) begin errors++; $display("FAIL read_data: got %h expected 1234", rd_at_ready); end
    checks++; if (rv_at_ready !== 1'b1 || rv_cnt != 1) begin errors++; $display("FAIL read_valid: got at_ready=%b pulses=%0d expected 1/1", rv_at_ready, rv_cnt); end
    checks++; if (ack_at_ready !== 1'b0) begin errors++; $display("FAIL read_ack: got %b expected 0", ack_at_ready); end
    checks++; if (ready_at != 260) begin errors++; $display("FAIL read_ready_time: got %0d expected 260", ready_at); end
    exp_rd[0] = 16'h1234;
  endtask

  task automatic test_no_phy;
    run_frame(0, 1'b0, 5'h07, 5'h1f, 16'h0, 1'b1, 16'hffff, 1'b0, -1);
    checks++; if (ack_at_ready !== 1'b1) begin errors++; $display("FAIL nophy_ack: got %b expected 1", ack_at_ready); end
    checks++; if (rd_at_ready !== 16'hffff) begin errors++; $display("FAIL nophy_data: got %h expected ffff", rd_at_ready); end
    exp_rd[0] = 16'hffff;
    run_frame(0, 1'b1, 5'h03, 5'h04, 16'h5a5a, 1'b0, 16'h0, 1'b0, -1);
    checks++; if (ack_at_accept !== 1'b0) begin errors++; $display("FAIL nophy_ack_clear: got %b expected 0", ack_at_accept); end
    checks++; if (rd_at_ready !== exp_rd[0]) begin errors++; $display("FAIL write_keeps_read_data: got %h expected %h", rd_at_ready, exp_rd[0]); end
  endtask

  task automatic test_ignore_start;
    run_frame(0, 1'b1, 5'h0a, 5'h15, 16'hc3c3, 1'b0, 16'h0, 1'b1, -1);
    checks++; if (bit_diffs(32, 1'b1, 5'h0a, 5'h15, 16'hc3c3) != 0) begin errors++; $display("FAIL ignore_bits: got %0d bad bits expected 0", bit_diffs(32, 1'b1, 5'h0a, 5'h15, 16'hc3c3)); end
    checks++; if (ready_at != 260 || ready_drop !== 1'b0 || tog_cyc.size() != 128) begin errors++; $display("FAIL ignore_single_txn: got ready_at=%0d drop=%b toggles=%0d expected 260/0/128", ready_at, ready_drop, tog_cyc.size()); end
  endtask

  task automatic test_reset_mid_read;
    run_frame(0, 1'b0, 5'h05, 5'h06, 16'h0, 1'b0, 16'ha5a5, 1'b0, 203);
    checks++; if (mdc_a !== 1'b0 || o_a !== 1'b1 || oe_a !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL midreset_pins: got mdc=%b o=%b oe=%b ready=%b expected 0 1 0 1", mdc_a, o_a, oe_a, ready_a); end
    checks++; if (rd_a !== 16'h0 || ack_a !== 1'b0) begin errors++; $display("FAIL midreset_read: got rd=%h ack=%b expected 0000 0", rd_a, ack_a); end
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv_a === 1'b1) rv_cnt++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv_a === 1'b1) rv_cnt++;
    end
    checks++; if (rv_cnt != 0) begin errors++; $display("FAIL midreset_valid: got %0d pulses expected 0", rv_cnt); end
    run_frame(0, 1'b1, 5'h1e, 5'h01, 16'h0f0f, 1'b0, 16'h0, 1'b0, -1);
    checks++; if (bit_diffs(32, 1'b1, 5'h1e, 5'h01, 16'h0f0f) != 0 || ready_at != 260) begin errors++; $display("FAIL midreset_recover: got bad=%0d ready_at=%0d expected 0/260", bit_diffs(32, 1'b1, 5'h1e, 5'h01, 16'h0f0f), ready_at); end
    checks++; if (rd_at_ready !== 16'h0) begin errors++; $display("FAIL midreset_data_kept: got %h expected 0000", rd_at_ready); end
  endtask

  task automatic test_short_frame;
    run_frame(1, 1'b1, 5'h19, 5'h0c, 16'h6d2b, 1'b0, 16'h0, 1'b0, -1);
    checks++; if (bit_diffs(0, 1'b1, 5'h19, 5'h0c, 16'h6d2b) != 0) begin errors++; $display("FAIL short_bits: got %0d bad bits expected 0", bit_diffs(0, 1'b1, 5'h19, 5'h0c, 16'h6d2b)); end
    checks++; if (phase_diffs(3, 32) != 0) begin errors++; $display("FAIL short_mdc_phase: got %0d bad toggles expected 0", phase_diffs(3, 32)); end
    checks++; if (ready_at != 198) begin errors++; $display("FAIL short_ready_time: got %0d expected 198", ready_at); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int          s  = int'($urandom_range(0, 1));
      int          cd = (s != 0) ? 3 : 2;
      int          pl = (s != 0) ? 0 : 32;
      logic        wr = 1'($urandom);
      logic [4:0]  pa = 5'($urandom);
      logic [4:0]  ra = 5'($urandom);
      logic [15:0] dt = 16'($urandom);
      logic        ta = ($urandom_range(0, 3) == 0);
      logic [15:0] pd = 16'($urandom);
      logic [15:0] erd;
      run_frame(s, wr, pa, ra, dt, ta, pd, 1'b0, -1);
      erd = wr ? exp_rd[s] : pd;
      checks++; if (bit_diffs(pl, wr, pa, ra, dt) != 0) begin errors++; $display("FAIL rand_bits[%0d]: got %0d bad bits expected 0", it, bit_diffs(pl, wr, pa, ra, dt)); end
      checks++; if (oe_diffs(pl, cd, wr) != 0 || phase_diffs(cd, pl + 32) != 0) begin errors++; $display("FAIL rand_timing[%0d]: got oe_bad=%0d phase_bad=%0d expected 0/0", it, oe_diffs(pl, cd, wr), phase_diffs(cd, pl + 32)); end
      checks++; if (ready_at != (pl + 33) * 2 * cd) begin errors++; $display("FAIL rand_ready[%0d]: got %0d expected %0d", it, ready_at, (pl + 33) * 2 * cd); end
      checks++; if (rv_cnt != (wr ? 0 : 1) || ack_at_accept !== 1'b0) begin errors++; $display("FAIL rand_valid[%0d]: got pulses=%0d ack_at_accept=%b expected %0d/0", it, rv_cnt, ack_at_accept, wr ? 0 : 1); end
      checks++; if (rd_at_ready !== erd || ack_at_ready !== (wr ? 1'b0 : ta)) begin errors++; $display("FAIL rand_result[%0d]: got rd=%h ack=%b expected rd=%h ack=%b", it, rd_at_ready, ack_at_ready, erd, wr ? 1'b0 : ta); end
      exp_rd[s] = erd;
    end
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; write = 1'b0;
    phy_addr = '0; reg_addr = '0; content = '0; mdio_i_a = 1'b1; mdio_i_b = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b1;
    @(negedge clk);
    test_write;
    test_read;
    test_no_phy;
    test_ignore_start;
    test_reset_mid_read;
    test_short_frame;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ethernet_smi_master.md
# ethernet_smi_master

Parametrised SMI/MDIO management master for the Ethernet PHY: performs both clause-22 register writes and reads, with configurable PHY address, MDC divider and preamble length. Sits between the Ethernet control logic and the PHY management pins. External split-pin MDIO drives a top-level tri-state buffer.

## Interface
- CLK_DIV, 10, MDC half-period in clk cycles (≥2)
- PREAMBLE_LEN, 32, number of preamble ones sent before ST (0..32)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while ready=1
- write  in  1  1 = write transaction, 0 = read (latched at start)
- phy_addr  in  5  PHY address (latched at start)
- register  in  5  PHY register address (latched at start)
- content  in  16  write data (latched at start)
- ethernet_mdc  out  1  management clock to PHY
- ethernet_mdio_o  out  1  MDIO output value
- ethernet_mdio_oe  out  1  MDIO output enable (1 = drive)
- ethernet_mdio_i  in  1  MDIO pin input
- ready  out  1  idle, may accept start
- read_data  out  16  last read result
- read_valid  out  1  one-cycle pulse when read_data updates
- ack_error  out  1  PHY did not pull TA low on last read

## Operation
- Reset values: ethernet_mdc=0, mdio_o=1, mdio_oe=0, ready=1, read_data=0, read_valid=0, ack_error=0, state IDLE.
- Frame, MSB first: PREAMBLE_LEN ones, ST=01, OP=01 (write)/10 (read), phy_addr[4:0], register[4:0], TA, DATA[15:0].
- States: IDLE → PRE (skipped if PREAMBLE_LEN=0) → HDR (14 bits ST..REGAD) → TA (2 bits) → DATA (16 bits) → END → IDLE.
- Write: TA driven 1 then 0; DATA driven from content; mdio_oe=1 throughout PRE..DATA.
- Read: mdio_oe=0 from first TA bit through DATA. mdio_i sampled at second TA bit rising MDC: 1 → ack_error=1. DATA sampled at each MDC rising edge into shift register; read_data updated at end regardless of ack_error.
- END: mdio_oe=0, mdio_o=1, MDC held low for 2*CLK_DIV cycles, then ready=1.
- ack_error cleared on every accepted start; holds otherwise. read_data holds until next read completes; writes never alter it.
- start while ready=0 ignored; input changes after acceptance have no effect.
- Reset asserted mid-frame: immediate return to reset values, no partial completion, no read_valid.

## Timing
- Divider counter runs 0..CLK_DIV-1 only while not IDLE; each wrap toggles MDC (PRE..DATA).
- Bit period = 2*CLK_DIV clk cycles. Bit value/oe changes on the edge MDC falls (first bit: the start-accept edge); MDC rises CLK_DIV cycles later; mdio_i sampled on that same edge.
- ready falls on the start-accept edge and rises exactly (PREAMBLE_LEN+33)*2*CLK_DIV cycles later.
- read_valid high for the single cycle where ready returns to 1 (reads only); read_data and ack_error valid same cycle.
- MDC never has a glitch or short phase: every high and low phase is exactly CLK_DIV cycles.

## Test plan
- Write, CLK_DIV=2, PREAMBLE_LEN=32, phy_addr=1, register=0, content=16'h8000 → decoded MDIO at MDC rise: 32×1, 01 01 00001 00000 10 1000_0000_0000_0000; oe=1 whole frame; ready back after 260 cycles; read_valid never asserted.
- Read, PHY model drives 0 on TA2 and 16'h1234 → oe=0 from TA1; read_data=16'h1234, read_valid one cycle, ack_error=0, ready after 260 cycles.
- Read with mdio_i held 1 (no PHY) → ack_error=1, read_data=16'hFFFF; next start clears ack_error on accept edge.
- start pulsed and register/content changed mid-write → second request ignored, frame unchanged, exactly one transaction.
- reset low during DATA of a read → outputs immediately to reset values, read_data stays 0, no read_valid; fresh write afterwards completes normally.
- PREAMBLE_LEN=0, CLK_DIV=3 → frame starts with ST=01, ready returns after 198 cycles, every MDC phase 3 cycles.
